uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO between the datapath's UART store path and the UART transmitter.
//  Absorbs bursts of stores to the UART TX address so the CPU is not held off
//  per byte. Drives the transmitter's DataIn/DataInValid; it advances on DataInReady.
//  First-word-fall-through. Single clock domain.
// PARAMETERS
//  DATA_WIDTH  8  byte width of each entry
//  DEPTH_LOG2  4  log2 of entry count (DEPTH = 16); DEPTH_LOG2 >= 1
// PORTS
//  clk           in   1             system clock, rising edge
//  rst_n         in   1             asynchronous reset, active-low
//  in_data       in   DATA_WIDTH    byte from datapath store
//  in_valid      in   1             datapath offers in_data this cycle
//  in_ready      out  1             FIFO can accept (= !full)
//  out_data      out  DATA_WIDTH    head byte to UART DataIn
//  out_valid     out  1             head valid, to UART DataInValid (= !empty)
//  out_ready     in   1             UART DataInReady
//  count         out  DEPTH_LOG2+1  occupied entries, 0..DEPTH
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  overflow      out  1             sticky: push attempted while full
//  clr_overflow  in   1             clears overflow
// BEHAVIOUR
//  - Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    in_ready=1, out_valid=0, overflow=0, out_data=0. Storage not cleared.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both at rising edge.
//  - push: mem[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1 mod DEPTH.
//    pop: rd_ptr<=rd_ptr+1 mod DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - full/empty/in_ready/out_valid derive from the registered count. No
//    combinational in->out path.
//  - Latency: byte pushed into empty FIFO at edge N -> out_valid=1 and out_data
//    valid after edge N. No same-cycle bypass.
//  - out_data = mem[rd_ptr] (FWFT). Stable while out_valid & !out_ready.
//  - Empty: out_ready ignored, rd_ptr holds.
//  - Full: in_valid refused (in_ready=0) even if a pop occurs that cycle.
//    A pop while full frees one slot from the next cycle.
//  - Empty: push alone -> count=1. Pop cannot occur.
//  - Pointers wrap at DEPTH-1 -> 0. Full vs empty resolved by count, not pointers.
//  - overflow: set at edge where in_valid & full. Cleared by clr_overflow.
//    If set and clear occur in the same cycle, set wins.
//  - Reset mid-transfer: all queued bytes discarded. UART sees out_valid drop
//    asynchronously with rst_n.
// CONFIGURATION
//  UART_TX_FIFO_STATS_EN defined:
//   - adds port drop_count out 16: counts refused pushes (in_valid & full).
//   - Saturates at 16'hFFFF. Reset 0. Cleared by clr_overflow unless a drop
//     occurs that cycle, in which case it loads 1.
//   - Adds port hiwater out DEPTH_LOG2+1: maximum count since reset/clr_overflow.
//  Undefined: neither port exists. No statistics logic is synthesized.
// TESTING
//  - Reset, then push 8'hA5 with out_ready=0 -> next cycle out_valid=1,
//    out_data=8'hA5, count=1, empty=0.
//  - Push 16 bytes 0x00..0x0F, out_ready=0 -> full=1, in_ready=0, count=16.
//    Then 17th push 0xFF -> overflow=1, FIFO contents unchanged.
//  - Drain full FIFO with out_ready=1 -> out_data 0x00..0x0F on consecutive
//    cycles, then empty=1, out_valid=0.
//  - At count=5, push and pop together for 40 cycles:
//    - count stays 5 throughout.
//    - Output order matches input order across pointer wrap.
//  - overflow=1 with clr_overflow=1 and in_valid on full in same cycle ->
//    overflow stays 1. Next cycle clr_overflow alone -> overflow=0.
//  - Assert rst_n=0 mid-drain at count=9 -> immediately count=0, out_valid=0,
//    in_ready=1. After release, first push reads back correctly.
//    With STATS_EN: 3 refused pushes -> drop_count=3, hiwater=16.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte stream handshake (data/valid/ready) between the store path, the TX FIFO and the UART.
// The master drives data and valid. The slave drives ready.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter from the store path.
// Optional statistics (drop_count, hiwater) are enabled with UART_TX_FIFO_STATS_EN.
module uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_tx_fifo_if.slave         in_if,
   uart_tx_fifo_if.master        out_if,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   input  logic                  clr_overflow
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]           drop_count,
   output logic [DEPTH_LOG2:0]   hiwater
`endif
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned PW    = DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  push, pop;

   assign push = in_if.valid & ~full_q;
   assign pop  = out_if.ready & ~empty_q;

   // Next-state pointers, occupancy and the registered head byte.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == CW'(0));
      // The slot being written this edge becomes the head when it is the next read slot.
      out_data_d = mem_q[rd_ptr_d];
      if (push && (rd_ptr_d == wr_ptr_q)) out_data_d = in_if.data;
      if (clr_overflow) overflow_d = 1'b0;
      if (in_if.valid && full_q) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         out_data_q <= out_data_d;
      end
   end

   // Storage is intentionally left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_if.data;
   end

   assign in_if.ready  = ~full_q;
   assign out_if.valid = ~empty_q;
   assign out_if.data  = out_data_q;
   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign overflow     = overflow_q;

`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]   drop_count_q, drop_count_d;
   logic [CW-1:0] hiwater_q, hiwater_d;
   logic          drop;

   // A drop in the clearing cycle restarts the count at one.
   always_comb begin
      drop         = in_if.valid & full_q;
      drop_count_d = drop_count_q;
      hiwater_d    = hiwater_q;
      if (drop) begin
         if (clr_overflow)                  drop_count_d = 16'd1;
         else if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      end else if (clr_overflow) begin
         drop_count_d = '0;
      end
      if (clr_overflow)            hiwater_d = count_d;
      else if (count_d > hiwater_q) hiwater_d = count_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count_q <= '0;
         hiwater_q    <= '0;
      end else begin
         drop_count_q <= drop_count_d;
         hiwater_q    <= hiwater_d;
      end
   end

   assign drop_count = drop_count_q;
   assign hiwater    = hiwater_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_uart_tx_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned DL    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr_overflow = 1'b0;
   logic [DL:0]   count;
   logic          full, empty, overflow;
`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]   drop_count;
   logic [DL:0]   hiwater;
`endif

   uart_tx_fifo_if #(.DATA_WIDTH(DW)) in_if ();
   uart_tx_fifo_if #(.DATA_WIDTH(DW)) out_if ();

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_if        (in_if),
      .out_if       (out_if),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .drop_count   (drop_count),
      .hiwater      (hiwater)
`endif
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: queue of bytes in arrival order plus sticky overflow.
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       clr;
      int         e_cnt;
      logic       e_ov;
      logic [7:0] e_data;
      logic       e_full;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".count"},     32'(count),        32'(mq.size()));
      chk({tag, ".empty"},     32'(empty),        32'(mq.size() == 0));
      chk({tag, ".full"},      32'(full),         32'(mq.size() == DEPTH));
      chk({tag, ".in_ready"},  32'(in_if.ready),  32'(mq.size() != DEPTH));
      chk({tag, ".out_valid"}, 32'(out_if.valid), 32'(mq.size() != 0));
      chk({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
      if (mq.size() != 0) chk({tag, ".out_data"}, 32'(out_if.data), 32'(mq[0]));
   endtask

   // One clock: drive at negedge, model updates on the edge, sample 1 ns later.
   task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic clr, input string tag);
      int sz;
      @(negedge clk);
      in_if.valid  = iv;
      in_if.data   = d;
      out_if.ready = ordy;
      clr_overflow = clr;
      @(posedge clk);
      sz = mq.size();
      if (ordy && sz > 0) void'(mq.pop_front());
      if (iv && sz < DEPTH) mq.push_back(d);
      m_ovf = (iv && sz == DEPTH) || (m_ovf && !clr);
      #1;
      check_model(tag);
      in_if.valid  = 1'b0;
      out_if.ready = 1'b0;
      clr_overflow = 1'b0;
   endtask

   // Asynchronous reset asserted between edges and checked before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.count",     32'(count),        32'd0);
      chk("rst.out_valid", 32'(out_if.valid), 32'd0);
      chk("rst.in_ready",  32'(in_if.ready),  32'd1);
      chk("rst.empty",     32'(empty),        32'd1);
      chk("rst.full",      32'(full),         32'd0);
      chk("rst.overflow",  32'(overflow),     32'd0);
      chk("rst.out_data",  32'(out_if.data),  32'd0);
`ifdef UART_TX_FIFO_STATS_EN
      chk("rst.drop_count", 32'(drop_count), 32'd0);
      chk("rst.hiwater",    32'(hiwater),    32'd0);
`endif
      mq.delete();
      m_ovf = 1'b0;
      in_if.valid  = 1'b0;
      out_if.ready = 1'b0;
      clr_overflow = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int pin, por;
      logic [7:0] b;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b0;

      //        iv    d      ordy  clr   cnt  ov    data   full  ovf
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b1, 8'h77, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h11, 1'b0, 1'b0};

      do_reset();

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr, "vec");
         chk($sformatf("vec%0d.count", i),     32'(count),        32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d.out_valid", i), 32'(out_if.valid), 32'(tbl[i].e_ov));
         chk($sformatf("vec%0d.full", i),      32'(full),         32'(tbl[i].e_full));
         chk($sformatf("vec%0d.overflow", i),  32'(overflow),     32'(tbl[i].e_ovf));
         if (tbl[i].e_ov)
            chk($sformatf("vec%0d.out_data", i), 32'(out_if.data), 32'(tbl[i].e_data));
      end

      // Single push into an empty FIFO shows up right after the edge.
      do_reset();
      step(1'b1, 8'hA5, 1'b0, 1'b0, "first");
      chk("first.out_data", 32'(out_if.data), 32'hA5);
      chk("first.count",    32'(count),       32'd1);

      // Fill to full, then a refused 17th push sets overflow.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      chk("fill.full",     32'(full),        32'd1);
      chk("fill.in_ready", 32'(in_if.ready), 32'd0);
      chk("fill.count",    32'(count),       32'd16);
      step(1'b1, 8'hFF, 1'b0, 1'b0, "ovf");
      chk("ovf.overflow", 32'(overflow),    32'd1);
      chk("ovf.head",     32'(out_if.data), 32'h00);

      // Set beats clear in the same cycle; a lone clear then drops it.
      step(1'b1, 8'hEE, 1'b0, 1'b1, "setclr");
      chk("setclr.overflow", 32'(overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
      chk("clr.overflow", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
      for (int i = 0; i < 3; i++) step(1'b1, 8'hDD, 1'b0, 1'b0, "drop");
      chk("stats.drop_count", 32'(drop_count), 32'd3);
      chk("stats.hiwater",    32'(hiwater),    32'd16);
`endif

      // Full pop frees a slot only from the next cycle.
      step(1'b1, 8'hCC, 1'b1, 1'b0, "fullpop");
      chk("fullpop.count", 32'(count), 32'd15);
      step(1'b1, 8'h0F, 1'b0, 1'b0, "refill");

      // Drain in order on consecutive cycles.
      for (int i = 1; i < 17; i++) begin
         b = (i == 16) ? 8'h0F : 8'(i);
         chk($sformatf("drain%0d.head", i), 32'(out_if.data), 32'(b));
         step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      end
      chk("drain.empty",     32'(empty),        32'd1);
      chk("drain.out_valid", 32'(out_if.valid), 32'd0);

      // Steady push+pop at count 5 across pointer wrap.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre5");
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, "steady");
         chk("steady.count", 32'(count), 32'd5);
      end

      // Reset in the middle of a drain at count 9.
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "pre9");
      for (int i = 0; i < 3; i++)  step(1'b0, 8'h00, 1'b1, 1'b0, "drain9");
      chk("mid.count", 32'(count), 32'd9);
      out_if.ready = 1'b1;
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0, "after_rst");
      chk("after_rst.out_data", 32'(out_if.data), 32'h5A);

      // Randomized traffic in phases of differing push/pop pressure.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         pin = (p == 0) ? 80 : (p == 1) ? 50 : (p == 2) ? 30 : 95;
         por = (p == 0) ? 30 : (p == 1) ? 50 : (p == 2) ? 85 : 60;
         for (int i = 0; i < 150; i++)
            step(($urandom_range(0, 99) < pin), 8'($urandom), ($urandom_range(0, 99) < por),
                 ($urandom_range(0, 19) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
